// File: rtl/alu_seq.sv
// Sequential ALU with a ready/valid handshake. Define ALU_SEQ_MULDIV_EN to build the
// iterative multiply/divide datapath (shift-add multiply, restoring divide).
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             out_ready,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] res_o,
    output logic             div_zero_o
);

    localparam int SW = $clog2(WIDTH);

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] res_q;
    logic             dz_q;
    logic [WIDTH-1:0] quick_res;
    logic             quick_dz;
    logic [SW-1:0]    sh;

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [SW:0] CNT_LAST = (SW+1)'(WIDTH);

    logic               use_calc;
    logic [SW:0]        cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd;
    logic               mul_q;
    logic               hi_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   fin_res;
`endif

    assign sh = b[SW-1:0];

    always_comb begin
        quick_res = '0;
        quick_dz  = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
        use_calc  = 1'b0;
`endif
        case (op)
            4'b0000: quick_res = a + b;
            4'b0001: quick_res = a - b;
            4'b0010: quick_res = a & b;
            4'b0011: quick_res = a | b;
            4'b0100: quick_res = a ^ b;
            4'b0101: quick_res = a << sh;
            4'b0110: quick_res = a >> sh;
            4'b0111: quick_res = WIDTH'($signed(a) >>> sh);
            4'b1000: quick_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1001: quick_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_SEQ_MULDIV_EN
            4'b1010, 4'b1011: use_calc = 1'b1;
            // A zero divisor is resolved immediately instead of iterating.
            4'b1100: begin
                if (b == '0) begin
                    quick_res = '1;
                    quick_dz  = 1'b1;
                end else begin
                    use_calc = 1'b1;
                end
            end
            4'b1101: begin
                if (b == '0) begin
                    quick_res = a;
                    quick_dz  = 1'b1;
                end else begin
                    use_calc = 1'b1;
                end
            end
`endif
            default: quick_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // acc holds {high product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        if (mul_q) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
        end
        fin_res = hi_q ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            res_q <= '0;
            dz_q  <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            mul_q <= 1'b0;
            hi_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
                        if (use_calc) begin
                            mul_q <= ~op[2];
                            hi_q  <= op[0];
                            acc   <= {{WIDTH{1'b0}}, (op[2] ? a : b)};
                            opnd  <= op[2] ? b : a;
                            cnt   <= '0;
                            state <= CALC;
                        end else begin
                            res_q <= quick_res;
                            dz_q  <= quick_dz;
                            state <= DONE;
                        end
`else
                        res_q <= quick_res;
                        dz_q  <= quick_dz;
                        state <= DONE;
`endif
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                // WIDTH iterations, then one edge to publish the result.
                CALC: begin
                    if (cnt == CNT_LAST) begin
                        res_q <= fin_res;
                        dz_q  <= 1'b0;
                        state <= DONE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign res_o       = res_q;
    assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32) using a scoreboard queue of expected results.
// Expectations follow ALU_SEQ_MULDIV_EN when that macro is defined for the build.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_ready;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] res_o;
    logic        div_zero_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];

`ifdef ALU_SEQ_MULDIV_EN
    localparam int LONG_LAT = 33;
`else
    localparam int LONG_LAT = 1;
`endif

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .op(op),
        .out_ready(out_ready),
        .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o),
        .res_o(res_o),
        .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [3:0] o, input string tag);
        exp_t        e;
        logic [63:0] p;
        logic [4:0]  s;
        p = {32'b0, x} * {32'b0, y};
        s = y[4:0];
        e.res = '0;
        e.dz  = 1'b0;
        e.lat = 1;
        e.tag = tag;
        case (o)
            4'd0: e.res = x + y;
            4'd1: e.res = x - y;
            4'd2: e.res = x & y;
            4'd3: e.res = x | y;
            4'd4: e.res = x ^ y;
            4'd5: e.res = x << s;
            4'd6: e.res = x >> s;
            4'd7: e.res = 32'($signed(x) >>> s);
            4'd8: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9: e.res = (x < y) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MULDIV_EN
            4'd10: begin e.res = p[31:0];  e.lat = 33; end
            4'd11: begin e.res = p[63:32]; e.lat = 33; end
            4'd12: begin
                if (y == 0) begin e.res = 32'hFFFF_FFFF; e.dz = 1'b1; end
                else begin e.res = x / y; e.lat = 33; end
            end
            4'd13: begin
                if (y == 0) begin e.res = x; e.dz = 1'b1; end
                else begin e.res = x % y; e.lat = 33; end
            end
`endif
            default: e.res = '0;
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input string tag, input logic [31:0] x, input logic [31:0] y,
                                 input logic [3:0] o, input logic [31:0] r, input logic z,
                                 input int lat);
        exp_t e;
        @(negedge clk);
        check({tag, "_ready"}, 64'(in_ready_o), 64'd1);
        a = x;
        b = y;
        op = o;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.res = r;
        e.dz  = z;
        e.lat = lat;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Scrambles inputs while the DUT is busy, then optionally stalls the consumer.
    task automatic checkOutput(input int stall);
        exp_t e;
        int   lat;
        e = sb.pop_front();
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid_o) begin
                a = $urandom;
                b = $urandom;
                op = 4'($urandom);
                in_valid = 1'($urandom);
            end
        end while (!out_valid_o && lat < 100);
        in_valid = 1'b0;
        check({e.tag, "_lat"}, 64'(lat), 64'(e.lat));
        check({e.tag, "_res"}, 64'(res_o), 64'(e.res));
        check({e.tag, "_dz"}, 64'(div_zero_o), 64'(e.dz));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            @(posedge clk);
            #1;
            check({e.tag, "_stall_res"}, 64'(res_o), 64'(e.res));
            check({e.tag, "_stall_valid"}, 64'(out_valid_o), 64'd1);
            check({e.tag, "_stall_ready"}, 64'(in_ready_o), 64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({e.tag, "_idle_ready"}, 64'(in_ready_o), 64'd1);
        check({e.tag, "_idle_valid"}, 64'(out_valid_o), 64'd0);
        check({e.tag, "_idle_hold"}, 64'(res_o), 64'(e.res));
    endtask

    initial begin
        exp_t        m;
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  o;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_res", 64'(res_o), 64'd0);
        check("rst_dz", 64'(div_zero_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("add_wrap", 32'hFFFF_FFFF, 32'h1, 4'd0, 32'h0, 1'b0, 1);
        checkOutput(0);
        applyStimulus("sub", 32'h0, 32'h1, 4'd1, 32'hFFFF_FFFF, 1'b0, 1);
        checkOutput(0);
        applyStimulus("xor", 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd4, 32'hFF00_EDCB, 1'b0, 1);
        checkOutput(0);
        applyStimulus("sll", 32'h0000_0003, 32'hFFFF_FFE4, 4'd5, 32'h0000_0030, 1'b0, 1);
        checkOutput(0);
        applyStimulus("srl", 32'h8000_0000, 32'h0000_001F, 4'd6, 32'h0000_0001, 1'b0, 1);
        checkOutput(0);
        applyStimulus("sra", 32'h8000_0000, 32'h0000_0024, 4'd7, 32'hF800_0000, 1'b0, 1);
        checkOutput(0);
        applyStimulus("slt", 32'hFFFF_FFFF, 32'h1, 4'd8, 32'h1, 1'b0, 1);
        checkOutput(0);
        applyStimulus("sltu", 32'hFFFF_FFFF, 32'h1, 4'd9, 32'h0, 1'b0, 1);
        checkOutput(0);
        applyStimulus("op_1111", 32'h1234_5678, 32'h9, 4'd15, 32'h0, 1'b0, 1);
        checkOutput(0);
`ifdef ALU_SEQ_MULDIV_EN
        applyStimulus("mulhu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11, 32'hFFFF_FFFE, 1'b0, LONG_LAT);
        checkOutput(0);
        applyStimulus("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'h0000_0001, 1'b0, LONG_LAT);
        checkOutput(0);
        applyStimulus("divu", 32'd100, 32'd7, 4'd12, 32'd14, 1'b0, LONG_LAT);
        checkOutput(0);
        applyStimulus("remu", 32'd100, 32'd7, 4'd13, 32'd2, 1'b0, LONG_LAT);
        checkOutput(0);
        applyStimulus("divu_zero", 32'd5, 32'd0, 4'd12, 32'hFFFF_FFFF, 1'b1, 1);
        checkOutput(0);
        applyStimulus("remu_zero", 32'd5, 32'd0, 4'd13, 32'd5, 1'b1, 1);
        checkOutput(0);
`else
        applyStimulus("mulhu_off", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11, 32'h0, 1'b0, 1);
        checkOutput(0);
        applyStimulus("divu_off", 32'd100, 32'd7, 4'd12, 32'h0, 1'b0, 1);
        checkOutput(0);
        applyStimulus("divu_zero_off", 32'd5, 32'd0, 4'd12, 32'h0, 1'b0, 1);
        checkOutput(0);
`endif
        applyStimulus("or_stall", 32'h1200_0034, 32'h0056_0000, 4'd3, 32'h1256_0034, 1'b0, 1);
        checkOutput(5);

        for (int i = 0; i < 12; i++) begin
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            o = 4'($urandom_range(0, 15));
            m = model(x, y, o, "rand");
            applyStimulus(m.tag, x, y, o, m.res, m.dz, m.lat);
            checkOutput(i % 4 == 1 ? 2 : 0);
        end

        // Abort a divide partway through; nothing may be delivered afterwards.
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        op = 4'd12;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 64'(in_ready_o), 64'd1);
        check("abort_valid", 64'(out_valid_o), 64'd0);
        check("abort_res", 64'(res_o), 64'd0);
        check("abort_dz", 64'(div_zero_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check("abort_quiet", 64'(out_valid_o), 64'd0);
        end
        applyStimulus("add_after", 32'd40, 32'd2, 4'd0, 32'd42, 1'b0, 1);
        checkOutput(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 8, 16, 32 and 64.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  4  operation code.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 in_ready_o  output  1  block can accept an operation.
REQ-011 out_valid_o  output  1  res_o and div_zero_o are valid.
REQ-012 res_o  output  WIDTH  registered result.
REQ-013 div_zero_o  output  1  the current result came from a divide or remainder with b==0.

Function
REQ-014 Opcodes SHALL be: 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor; 0101 sll; 0110 srl; 0111 sra; 1000 slt (signed); 1001 sltu (unsigned); 1010 mul (low WIDTH bits); 1011 mulhu (high WIDTH bits, unsigned); 1100 divu; 1101 remu; 1110 and 1111 give result 0.
REQ-015 Shift amount SHALL be b[log2(WIDTH)-1:0], and sra SHALL sign-fill from a[WIDTH-1].
REQ-016 slt and sltu SHALL return 1 or 0, zero-extended to WIDTH.
REQ-017 add, sub and mul SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-018 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-019 in_ready_o SHALL be 1 only in IDLE.
REQ-020 An operation SHALL be accepted only on a cycle where in_valid and in_ready_o are both 1; a, b and op SHALL be captured internally on that edge.
REQ-021 Single-cycle ops (0000-1001, 1110, 1111) and divide/remainder with b==0 SHALL go IDLE->DONE, with out_valid_o=1 on the cycle after acceptance (latency 1).
REQ-022 Mul and div ops with a nonzero divisor SHALL go IDLE->CALC and iterate one bit per cycle: shift-add for multiply, restoring division for divide.
REQ-023 A WIDTH-cycle counter SHALL drive CALC->DONE, so out_valid_o is asserted exactly WIDTH+1 cycles after acceptance.
REQ-024 divu by 0 SHALL return all ones, remu by 0 SHALL return a, and div_zero_o SHALL be 1 for both.
REQ-025 div_zero_o SHALL be 0 for every other result.
REQ-026 In DONE, out_valid_o SHALL stay 1 and res_o/div_zero_o SHALL hold stable until out_ready=1; on that edge the block SHALL return to IDLE.
REQ-027 in_valid SHALL be ignored outside IDLE; inputs may change freely during CALC without affecting the result.
REQ-028 out_ready SHALL be ignored outside DONE.
REQ-029 res_o SHALL retain the last delivered result while in IDLE and CALC; out_valid_o SHALL be 0 in those states.

Reset
REQ-030 rst SHALL force state IDLE, counter 0, res_o 0, div_zero_o 0, out_valid_o 0 and in_ready_o 1 on the next rising edge.
REQ-031 rst asserted in CALC or DONE SHALL abort the operation with no result delivered.
REQ-032 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-033 The macro ALU_SEQ_MULDIV_EN SHALL enable the multiply/divide datapath.
REQ-034 With ALU_SEQ_MULDIV_EN defined, opcodes 1010-1101 SHALL behave as specified in REQ-021 to REQ-024.
REQ-035 Without ALU_SEQ_MULDIV_EN, the CALC state, counter and mul/div datapath SHALL be absent; opcodes 1010-1101 SHALL complete with latency 1, result 0 and div_zero_o 0.

Verification (WIDTH=32)
REQ-036 add 0xFFFFFFFF+0x00000001, out_ready=1 -> out_valid_o on cycle after accept, res_o=0x00000000, return to IDLE.
REQ-037 slt a=0xFFFFFFFF,b=1 -> res_o=1; sltu same operands -> res_o=0; sra 0x80000000 by b=0x24 -> res_o=0xF8000000.
REQ-038 mulhu 0xFFFFFFFF*0xFFFFFFFF -> out_valid_o at cycle 33 after accept, res_o=0xFFFFFFFE; mul same operands -> res_o=0x00000001.
REQ-039 divu 100/7 -> res_o=14 at cycle 33; remu 100/7 -> res_o=2; divu 5/0 -> res_o=0xFFFFFFFF, div_zero_o=1, latency 1.
REQ-040 out_ready held 0 for 5 cycles in DONE -> res_o stable and in_ready_o=0 throughout; in_valid pulses in that window are ignored.
REQ-041 rst asserted 10 cycles into a divu -> next cycle in IDLE, out_valid_o=0, res_o=0, no result delivered; a following add completes normally.
